// File: rtl/pmu_vreg_pkg.sv
// Shared types and constants for the regulator ramp responder: FSM states,
// status-bus bit positions and the packed status layout.
package pmu_vreg_pkg;

  localparam int VREG_LVL_W = 12;

  localparam int PG_BIT    = 15;
  localparam int RAMP_BIT  = 14;
  localparam int FAULT_BIT = 13;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RAMP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_STABLE = 3'd3,
    ST_FAULT  = 3'd4
  } vreg_state_e;

  typedef struct packed {
    logic                  power_good;
    logic                  ramping;
    logic                  fault;
    logic                  rsvd;
    logic [VREG_LVL_W-1:0] level;
  } vreg_status_t;

endpackage

// File: rtl/vreg_step_calc.sv
// Combinational next-level computation: direction, step clamped to the
// remaining distance, and the optional VREG_SOFTSTART_EN reduced step.
module vreg_step_calc
  import pmu_vreg_pkg::*;
#(
  parameter int STEP_MV = 10,
  parameter int VMAX_MV = 1200
) (
  input  logic [VREG_LVL_W-1:0] level,
  input  logic [VREG_LVL_W-1:0] target,
`ifdef VREG_SOFTSTART_EN
  input  logic                  soft_start,
`endif
  output logic [VREG_LVL_W-1:0] next_level
);

  localparam logic [VREG_LVL_W-1:0] STEP_L = VREG_LVL_W'(STEP_MV);
  localparam logic [VREG_LVL_W-1:0] VMAX_L = VREG_LVL_W'(VMAX_MV);
`ifdef VREG_SOFTSTART_EN
  localparam int                    SOFT_MV = (STEP_MV / 2 < 1) ? 1 : STEP_MV / 2;
  localparam logic [VREG_LVL_W-1:0] SOFT_L  = VREG_LVL_W'(SOFT_MV);
`endif

  logic                  up;
  logic [VREG_LVL_W-1:0] step;
  logic [VREG_LVL_W-1:0] diff;
  logic [VREG_LVL_W-1:0] delta;
  logic [VREG_LVL_W-1:0] raw;

  always_comb begin
    step = STEP_L;
`ifdef VREG_SOFTSTART_EN
    if (soft_start) step = SOFT_L;
`endif
    up    = (target > level);
    diff  = up ? (target - level) : (level - target);
    // Clamping to the remaining distance means neither overshoot nor wrap.
    delta = (diff < step) ? diff : step;
    raw   = up ? (level + delta) : (level - delta);
    next_level = (raw > VMAX_L) ? VMAX_L : raw;
  end

endmodule

// File: rtl/vreg_ramp_responder.sv
// Regulator-side responder: slews the DAC level toward the registered mV target.
// Optional soft-start on the first ramp out of OFF: define VREG_SOFTSTART_EN.
//
// state  | meaning
// OFF    | rail off, level 0, waiting for a legal non-zero target
// RAMP   | stepping level toward target every STEP_CYCLES
// SETTLE | at target, counting SETTLE_CYCLES before power-good
// STABLE | at target, power-good asserted
// FAULT  | illegal target seen, level frozen until a legal target
module vreg_ramp_responder
  import pmu_vreg_pkg::*;
#(
  parameter int STEP_MV       = 10,
  parameter int STEP_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int VMIN_MV       = 500,
  parameter int VMAX_MV       = 1200,
  parameter int RESET_MV      = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [15:0]           vreg_ctrl,
  output logic [15:0]           vreg_status,
  output logic [VREG_LVL_W-1:0] dac_code,
  output logic                  busy
);

  localparam int                    TMR_W         = 16;
  localparam logic [TMR_W-1:0]      STEP_RELOAD   = TMR_W'(STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0]      SETTLE_RELOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]           VMIN_T        = 16'(VMIN_MV);
  localparam logic [15:0]           VMAX_T        = 16'(VMAX_MV);
  localparam logic [VREG_LVL_W-1:0] RESET_LVL     = VREG_LVL_W'(RESET_MV);

  vreg_state_e           state_q, state_d;
  logic [TMR_W-1:0]      step_tmr_q, step_tmr_d;
  logic [TMR_W-1:0]      settle_tmr_q, settle_tmr_d;
  logic [VREG_LVL_W-1:0] level_q, level_d;
  logic [15:0]           target_q, tgt_prev_q;
  logic [VREG_LVL_W-1:0] tgt_lvl;
  logic [VREG_LVL_W-1:0] next_level;
  logic                  tgt_legal;
  logic                  tgt_chg;
  vreg_status_t          status;

  assign tgt_lvl   = target_q[VREG_LVL_W-1:0];
  assign tgt_legal = (target_q[15:12] == 4'd0) &&
                     ((target_q == 16'd0) || ((target_q >= VMIN_T) && (target_q <= VMAX_T)));
  assign tgt_chg   = (target_q != tgt_prev_q);

`ifdef VREG_SOFTSTART_EN
  logic soft_q;
  logic soft_active;

  // Soft-start only applies to a ramp that begins from a fully discharged rail.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      soft_q <= 1'b0;
    end else if (state_q == ST_OFF && state_d == ST_RAMP) begin
      soft_q <= (level_q == '0);
    end else if (state_d != ST_RAMP) begin
      soft_q <= 1'b0;
    end
  end

  assign soft_active = soft_q && (level_q < VMIN_T[VREG_LVL_W-1:0]);
`endif

  vreg_step_calc #(
    .STEP_MV (STEP_MV),
    .VMAX_MV (VMAX_MV)
  ) u_step_calc (
    .level      (level_q),
    .target     (tgt_lvl),
`ifdef VREG_SOFTSTART_EN
    .soft_start (soft_active),
`endif
    .next_level (next_level)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_OFF;
      step_tmr_q   <= '0;
      settle_tmr_q <= '0;
      level_q      <= RESET_LVL;
      target_q     <= '0;
      tgt_prev_q   <= '0;
    end else begin
      state_q      <= state_d;
      step_tmr_q   <= step_tmr_d;
      settle_tmr_q <= settle_tmr_d;
      level_q      <= level_d;
      target_q     <= vreg_ctrl;
      tgt_prev_q   <= target_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    step_tmr_d   = step_tmr_q;
    settle_tmr_d = settle_tmr_q;
    level_d      = level_q;
    case (state_q)
      ST_OFF: begin
        if (!tgt_legal) begin
          state_d = ST_FAULT;
        end else if (target_q != 16'd0) begin
          state_d    = ST_RAMP;
          step_tmr_d = STEP_RELOAD;
        end
      end
      ST_RAMP: begin
        if (!tgt_legal) begin
          state_d = ST_FAULT;
        end else if (tgt_chg) begin
          step_tmr_d = STEP_RELOAD;
        end else if (step_tmr_q == '0) begin
          step_tmr_d = STEP_RELOAD;
          level_d    = next_level;
          if (next_level == tgt_lvl) begin
            state_d      = (tgt_lvl == '0) ? ST_OFF : ST_SETTLE;
            settle_tmr_d = SETTLE_RELOAD;
          end
        end else begin
          step_tmr_d = step_tmr_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!tgt_legal) begin
          state_d = ST_FAULT;
        end else if (tgt_chg) begin
          state_d    = ST_RAMP;
          step_tmr_d = STEP_RELOAD;
        end else if (settle_tmr_q == '0) begin
          state_d = ST_STABLE;
        end else begin
          settle_tmr_d = settle_tmr_q - 1'b1;
        end
      end
      ST_STABLE: begin
        if (!tgt_legal) begin
          state_d = ST_FAULT;
        end else if (tgt_chg) begin
          state_d    = ST_RAMP;
          step_tmr_d = STEP_RELOAD;
        end
      end
      ST_FAULT: begin
        if (tgt_legal) begin
          if (target_q == 16'd0 && level_q == '0) begin
            state_d = ST_OFF;
          end else begin
            state_d    = ST_RAMP;
            step_tmr_d = STEP_RELOAD;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    status            = '0;
    status.power_good = (state_q == ST_STABLE);
    status.ramping    = (state_q == ST_RAMP);
    status.fault      = (state_q == ST_FAULT);
    status.level      = level_q;
  end

  assign vreg_status = status;
  assign dac_code    = level_q;
  assign busy        = (state_q == ST_RAMP) || (state_q == ST_SETTLE);

endmodule

// File: tb/tb_vreg_ramp_responder.sv
// Directed self-checking bench for vreg_ramp_responder (default build).
module tb_vreg_ramp_responder;
  import pmu_vreg_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] vreg_ctrl;
  logic [15:0] vreg_status;
  logic [11:0] dac_code;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ctrl;
    int          ramp_cycles;
    logic [15:0] exp_status;
  } phase_t;

  phase_t tbl[4];

  vreg_ramp_responder dut (
    .clk         (clk),
    .rstn        (rstn),
    .vreg_ctrl   (vreg_ctrl),
    .vreg_status (vreg_status),
    .dac_code    (dac_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_to(input logic [11:0] lvl, input int max_cyc, output int n,
                        output logic [11:0] lo, output logic [11:0] hi);
    n  = 0;
    lo = dac_code;
    hi = dac_code;
    while (dac_code != lvl && n < max_cyc) begin
      step(1);
      n++;
      if (dac_code < lo) lo = dac_code;
      if (dac_code > hi) hi = dac_code;
    end
    check("level_reached", {20'd0, dac_code}, {20'd0, lvl});
  endtask

  task automatic wait_pg(output int n);
    n = 0;
    while (vreg_status[PG_BIT] !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
  endtask

  task automatic apply_phase(input int i);
    int          n;
    int          lo_bound, hi_bound;
    logic [11:0] lo, hi;
    logic [11:0] start;
    start = dac_code;
    vreg_ctrl = tbl[i].ctrl;
    step(2);
    check($sformatf("ph%0d_pg_drop", i), {31'd0, vreg_status[PG_BIT]}, 32'd0);
    check($sformatf("ph%0d_ramping", i), {31'd0, vreg_status[RAMP_BIT]}, 32'd1);
    run_to(tbl[i].ctrl[11:0], 2000, n, lo, hi);
    check($sformatf("ph%0d_ramp_cycles", i), n, tbl[i].ramp_cycles);
    lo_bound = (start < tbl[i].ctrl[11:0]) ? int'(start) : int'(tbl[i].ctrl[11:0]);
    hi_bound = (start > tbl[i].ctrl[11:0]) ? int'(start) : int'(tbl[i].ctrl[11:0]);
    check($sformatf("ph%0d_no_overshoot", i),
          {31'd0, (int'(lo) >= lo_bound) && (int'(hi) <= hi_bound)}, 32'd1);
    wait_pg(n);
    check($sformatf("ph%0d_settle_cycles", i), n, 16);
    check($sformatf("ph%0d_status", i), {16'd0, vreg_status}, {16'd0, tbl[i].exp_status});
  endtask

  initial begin
    int          n;
    logic [11:0] lo, hi;

    tbl[0] = '{16'd800,  80,  16'h8320};
    tbl[1] = '{16'd1000, 80,  16'h83E8};
    tbl[2] = '{16'd1005, 4,   16'h83ED};
    tbl[3] = '{16'd600,  120, 16'h8258};

    rstn      = 1'b0;
    vreg_ctrl = 16'd1000;
    step(3);
    check("reset_status", {16'd0, vreg_status}, 32'h0);
    check("reset_dac", {20'd0, dac_code}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;

    // Power-up ramp: one cycle of input latency, then one cycle to enter RAMP.
    step(2);
    check("up_status_ramp", {16'd0, vreg_status}, 32'h4000);
    check("up_busy", {31'd0, busy}, 32'd1);
    step(4);
    check("up_first_step", {20'd0, dac_code}, 32'd10);
    run_to(12'd1000, 2000, n, lo, hi);
    check("up_ramp_cycles", n + 4, 400);
    wait_pg(n);
    check("up_settle_cycles", n, 16);
    check("up_status", {16'd0, vreg_status}, 32'h83E8);
    check("up_busy_idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 3; i++) apply_phase(i);

    // Illegal targets freeze the level in FAULT.
    vreg_ctrl = 16'd1300;
    step(2);
    check("fault_status", {16'd0, vreg_status}, 32'h23ED);
    check("fault_busy", {31'd0, busy}, 32'd0);
    step(20);
    check("fault_frozen", {16'd0, vreg_status}, 32'h23ED);
    vreg_ctrl = 16'h1000;
    step(10);
    check("fault_hi_nibble", {16'd0, vreg_status}, 32'h23ED);
    vreg_ctrl = 16'd900;
    step(2);
    check("fault_exit", {16'd0, vreg_status}, 32'h43ED);
    run_to(12'd900, 2000, n, lo, hi);
    check("fault_recover_cycles", n, 44);
    wait_pg(n);
    check("fault_recover_status", {16'd0, vreg_status}, 32'h8384);

    apply_phase(3);

    // Reversal mid-ramp.
    vreg_ctrl = 16'd1000;
    step(2);
    run_to(12'd700, 2000, n, lo, hi);
    check("rev_to_700", n, 40);
    vreg_ctrl = 16'd650;
    step(2);
    check("rev_peak_now", {31'd0, dac_code <= 12'd710}, 32'd1);
    run_to(12'd650, 2000, n, lo, hi);
    check("rev_cycles", n, 20);
    check("rev_peak", {31'd0, hi <= 12'd710}, 32'd1);
    wait_pg(n);
    check("rev_settle", n, 16);
    check("rev_status", {16'd0, vreg_status}, 32'h828A);

    // Ramp to zero ends in OFF with no settle.
    vreg_ctrl = 16'd0;
    step(2);
    check("off_ramping", {16'd0, vreg_status}, 32'h428A);
    run_to(12'd0, 2000, n, lo, hi);
    check("off_cycles", n, 260);
    check("off_status", {16'd0, vreg_status}, 32'h0);
    check("off_busy", {31'd0, busy}, 32'd0);
    step(5);
    check("off_hold", {16'd0, vreg_status}, 32'h0);

    // Asynchronous reset mid-ramp.
    vreg_ctrl = 16'd1000;
    step(2);
    run_to(12'd300, 2000, n, lo, hi);
    check("ar_to_300", n, 120);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_dac", {20'd0, dac_code}, 32'h0);
    check("ar_status", {16'd0, vreg_status}, 32'h0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    step(2);
    rstn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
